// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD 7-segment scan display: scan states,
// active-high segment patterns {g,f,e,d,c,b,a}, digit indices and small helpers.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int DIG_ONES = 0;
  localparam int DIG_TENS = 1;
  localparam int DIG_HUND = 2;

  function automatic logic is_bcd(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // Active-low anode pattern that enables only the digit owned by a scan state.
  function automatic logic [2:0] anode_for(input scan_state_t st);
    logic [2:0] an_v;
    an_v = 3'b111;
    case (st)
      S_ONES:  an_v[DIG_ONES] = 1'b0;
      S_TENS:  an_v[DIG_TENS] = 1'b0;
      S_HUND:  an_v[DIG_HUND] = 1'b0;
      default: an_v = 3'b111;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit code to active-high 7-segment pattern {g..a};
// codes above 9 render as a dash. Output polarity is handled by the caller.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Code-to-pattern lookup.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Tear-free 3-digit multiplexed common-anode 7-segment driver with per-slot blanking.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on hundreds/tens.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bcd_valid,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hund,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done,
  output logic       digit_err
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic             SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]       SEG_IDLE  = SEG_INV ? ~SEG_OFF : SEG_OFF;

  scan_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_disp_ones;
  logic [3:0]       r_disp_tens;
  logic [3:0]       r_disp_hund;
  logic [3:0]       r_pend_ones;
  logic [3:0]       r_pend_tens;
  logic [3:0]       r_pend_hund;
  logic             r_pend_flag;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_frame_done;
  logic             r_digit_err;

  logic [3:0]       w_digit;
  logic [6:0]       w_pat;
  logic             w_in_blank;
  logic             w_blank_lead;
  logic             w_frame_end;
  logic [6:0]       w_seg_next;
  logic [2:0]       w_an_next;
  logic             w_load_en;
  logic [3:0]       w_load_ones;
  logic [3:0]       w_load_tens;
  logic [3:0]       w_load_hund;
  logic             w_load_ok;
  logic             w_err_set;

  bcd_to_seg7 u_seg7 (
    .i_code (w_digit),
    .o_seg  (w_pat)
  );

  assign w_in_blank  = (r_cnt < BLANK_END);
  assign w_frame_end = (r_state == S_HUND) && (r_cnt == CNT_MAX);

  // Digit owned by the current slot, and whether it is a suppressed leading zero.
  always_comb begin
    w_digit      = r_disp_ones;
    w_blank_lead = 1'b0;
    case (r_state)
      S_ONES:  w_digit = r_disp_ones;
      S_TENS:  w_digit = r_disp_tens;
      S_HUND:  w_digit = r_disp_hund;
      default: w_digit = r_disp_ones;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (r_state)
      S_HUND:  w_blank_lead = (r_disp_hund == 4'd0);
      S_TENS:  w_blank_lead = (r_disp_hund == 4'd0) && (r_disp_tens == 4'd0);
      default: w_blank_lead = 1'b0;
    endcase
`else
    w_blank_lead = 1'b0;
`endif
  end

  // Next segment/anode values; the anode stays asserted for a suppressed zero.
  always_comb begin
    w_seg_next = SEG_IDLE;
    w_an_next  = 3'b111;
    if (w_in_blank) begin
      w_seg_next = SEG_IDLE;
      w_an_next  = 3'b111;
    end else begin
      w_an_next = anode_for(r_state);
      if (w_blank_lead) begin
        w_seg_next = SEG_IDLE;
      end else if (SEG_INV) begin
        w_seg_next = ~w_pat;
      end else begin
        w_seg_next = w_pat;
      end
    end
  end

  // Frame-end load source: a same-cycle strobe overrides the pending copy.
  always_comb begin
    w_load_en = w_frame_end && (bcd_valid || r_pend_flag);
    if (bcd_valid) begin
      w_load_ones = bcd_ones;
      w_load_tens = bcd_tens;
      w_load_hund = bcd_hund;
    end else begin
      w_load_ones = r_pend_ones;
      w_load_tens = r_pend_tens;
      w_load_hund = r_pend_hund;
    end
    w_load_ok = w_load_en && is_bcd(w_load_ones) && is_bcd(w_load_tens)
                && is_bcd(w_load_hund);
    w_err_set = (r_cnt == BLANK_END) && !is_bcd(w_digit);
  end

  // Scan FSM, slot counter and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ONES;
      r_cnt        <= '0;
      r_seg        <= SEG_IDLE;
      r_an         <= 3'b111;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_done <= w_frame_end;
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        case (r_state)
          S_ONES:  r_state <= S_TENS;
          S_TENS:  r_state <= S_HUND;
          S_HUND:  r_state <= S_ONES;
          default: r_state <= S_ONES;
        endcase
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Pending capture, frame-boundary display update and sticky digit error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ones <= 4'd0;
      r_pend_tens <= 4'd0;
      r_pend_hund <= 4'd0;
      r_pend_flag <= 1'b0;
      r_disp_ones <= 4'd0;
      r_disp_tens <= 4'd0;
      r_disp_hund <= 4'd0;
      r_digit_err <= 1'b0;
    end else begin
      if (w_frame_end) begin
        if (w_load_en) begin
          r_disp_ones <= w_load_ones;
          r_disp_tens <= w_load_tens;
          r_disp_hund <= w_load_hund;
        end
        r_pend_flag <= 1'b0;
      end else if (bcd_valid) begin
        r_pend_ones <= bcd_ones;
        r_pend_tens <= bcd_tens;
        r_pend_hund <= bcd_hund;
        r_pend_flag <= 1'b1;
      end
      // A bad digit still on screen wins over a same-cycle clean reload.
      if (w_err_set) begin
        r_digit_err <= 1'b1;
      end else if (w_load_ok) begin
        r_digit_err <= 1'b0;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;
  assign digit_err  = r_digit_err;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan (REFRESH_DIV=8, BLANK_CYCLES=2,
// active-low segments); honours LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_seg_scan;

  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 3 * RD;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       bcd_valid = 1'b0;
  logic [3:0] bcd_ones  = 4'd0;
  logic [3:0] bcd_tens  = 4'd0;
  logic [3:0] bcd_hund  = 4'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;
  logic       digit_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BL),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_valid  (bcd_valid),
    .bcd_ones   (bcd_ones),
    .bcd_tens   (bcd_tens),
    .bcd_hund   (bcd_hund),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .digit_err  (digit_err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_hi(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int to_end();
    return FRAME - (cyc % FRAME);
  endfunction

  // Advance and check every cycle against displayed digits h/t/o (output lags by one edge).
  task automatic run(input int cycles, input int h, input int t, input int o);
    int n, c, slot, d;
    logic lead;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    for (int k = 0; k < cycles; k++) begin
      tick();
      n    = cyc - 1;
      c    = n % RD;
      slot = (n / RD) % 3;
      d    = (slot == 0) ? o : ((slot == 1) ? t : h);
      lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lead = ((slot == 2) && (h == 0)) || ((slot == 1) && (h == 0) && (t == 0));
`endif
      if (c < BL)         e_an = 3'b111;
      else if (slot == 0) e_an = 3'b110;
      else if (slot == 1) e_an = 3'b101;
      else                e_an = 3'b011;
      e_seg = ((c < BL) || lead) ? 7'h7F : ~seg_hi(d);
      chk_eq("an", 32'(an), 32'(e_an));
      chk_eq("seg", 32'(seg), 32'(e_seg));
      chk_eq("frame_done", 32'(frame_done), 32'((n % FRAME) == (FRAME - 1)));
    end
  endtask

  task automatic set_valid(input int h, input int t, input int o);
    bcd_hund  = 4'(h);
    bcd_tens  = 4'(t);
    bcd_ones  = 4'(o);
    bcd_valid = 1'b1;
  endtask

  initial begin
    #23;
    chk_eq("rst_an", 32'(an), 32'h7);
    chk_eq("rst_seg", 32'(seg), 32'h7F);
    chk_eq("rst_frame_done", 32'(frame_done), 32'h0);
    chk_eq("rst_digit_err", 32'(digit_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Frame 0: idle display 000
    run(FRAME, 0, 0, 0);
    chk_eq("err_idle", 32'(digit_err), 32'h0);

    // Frame 1: 2/5/5 strobed mid-frame, not shown until frame 2
    run(5, 0, 0, 0);
    set_valid(2, 5, 5);
    run(1, 0, 0, 0);
    bcd_valid = 1'b0;
    run(to_end(), 0, 0, 0);

    // Frame 2: shows 255; 1/2/3 then 4/5/6 strobed, latest wins
    run(3, 2, 5, 5);
    set_valid(1, 2, 3);
    run(1, 2, 5, 5);
    bcd_valid = 1'b0;
    run(6, 2, 5, 5);
    set_valid(4, 5, 6);
    run(1, 2, 5, 5);
    bcd_valid = 1'b0;
    run(to_end(), 2, 5, 5);

    // Frame 3: shows 456; 7/0/1 strobed exactly on the frame-end cycle
    run(FRAME - 1, 4, 5, 6);
    set_valid(7, 0, 1);
    run(1, 4, 5, 6);
    bcd_valid = 1'b0;

    // Frame 4: shows 701; load a non-BCD ones digit for next frame
    run(4, 7, 0, 1);
    set_valid(0, 0, 12);
    run(1, 7, 0, 1);
    bcd_valid = 1'b0;
    run(to_end(), 7, 0, 1);
    chk_eq("err_before_bad", 32'(digit_err), 32'h0);

    // Frame 5: ones shows dash, error sets on first drive cycle and sticks
    run(2, 0, 0, 12);
    chk_eq("err_in_blank", 32'(digit_err), 32'h0);
    run(1, 0, 0, 12);
    chk_eq("err_set", 32'(digit_err), 32'h1);
    run(5, 0, 0, 12);
    set_valid(3, 0, 0);
    run(1, 0, 0, 12);
    bcd_valid = 1'b0;
    run(to_end() - 1, 0, 0, 12);
    chk_eq("err_sticky", 32'(digit_err), 32'h1);
    run(1, 0, 0, 12);
    chk_eq("err_cleared", 32'(digit_err), 32'h0);

    // Frame 6: shows 300; queue 0/0/7
    run(10, 3, 0, 0);
    set_valid(0, 0, 7);
    run(1, 3, 0, 0);
    bcd_valid = 1'b0;
    run(to_end(), 3, 0, 0);

    // Frame 7: shows 007; pend 9/9/9 then reset during tens drive
    run(13, 0, 0, 7);
    set_valid(9, 9, 9);
    run(1, 0, 0, 7);
    bcd_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_eq("async_rst_an", 32'(an), 32'h7);
    chk_eq("async_rst_seg", 32'(seg), 32'h7F);
    chk_eq("async_rst_frame_done", 32'(frame_done), 32'h0);
    chk_eq("async_rst_digit_err", 32'(digit_err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Restart at ones slot; pending 999 must never appear
    run(2 * FRAME, 0, 0, 0);
    chk_eq("err_after_rst", 32'(digit_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
